// File: rtl/sa_pkg.sv
// Shared constants, accumulator sizing helper and FSM state type for the
// systolic matrix-multiply engine.
package sa_pkg;

  localparam int unsigned DefDW    = 8;
  localparam int unsigned DefFracW = 5;
  localparam int unsigned DefSaR   = 16;
  localparam int unsigned DefSaC   = 16;
  localparam int unsigned DefMDim  = 16;

  // Full-precision product plus enough headroom for M_DIM additions.
  function automatic int unsigned acc_w(input int unsigned d_w, input int unsigned m_dim);
    return 2 * d_w + $clog2(m_dim);
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StFeed,
    StOut,
    StDone
  } sa_state_e;

endpackage

// File: rtl/sa_pe.sv
// Output-stationary processing element: forwards A right and B down through
// registers and accumulates their signed product while enabled.
module sa_pe
  import sa_pkg::*;
#(
  parameter int unsigned D_W   = DefDW,
  parameter int unsigned ACC_W = acc_w(DefDW, DefMDim)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [D_W-1:0]   a_i,
  input  logic [D_W-1:0]   b_i,
  output logic [D_W-1:0]   a_o,
  output logic [D_W-1:0]   b_o,
  output logic [ACC_W-1:0] acc_o
);

  logic [D_W-1:0]          a_q, a_d;
  logic [D_W-1:0]          b_q, b_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic signed [2*D_W-1:0] prod;
  logic signed [ACC_W-1:0] prod_ext;

  // Multiply-accumulate and forwarding next state; clear wins over enable
  always_comb begin
    prod     = $signed(a_i) * $signed(b_i);
    prod_ext = ACC_W'(prod);
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    if (clr_i) begin
      a_d   = '0;
      b_d   = '0;
      acc_d = '0;
    end else if (en_i) begin
      a_d   = a_i;
      b_d   = b_i;
      acc_d = acc_q + prod_ext;
    end
  end

  // PE state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/sa_mm_engine.sv
// Output-stationary systolic matrix multiplier computing A*B in signed fixed
// point. Optional macro SA_MM_RND_EN selects round-half-up instead of floor
// when rescaling accumulators to D_W bits.
module sa_mm_engine
  import sa_pkg::*;
#(
  parameter int unsigned D_W    = DefDW,
  parameter int unsigned FRAC_W = DefFracW,
  parameter int unsigned SA_R   = DefSaR,
  parameter int unsigned SA_C   = DefSaC,
  parameter int unsigned M_DIM  = DefMDim
) (
  input  logic                                 I_CLK,
  input  logic                                 I_ASYN_RSTN,
  input  logic                                 I_SYNC_RSTN,
  input  logic                                 I_START,
  input  logic [0:SA_R-1][0:M_DIM-1][D_W-1:0]  I_MAT_1,
  input  logic [0:M_DIM-1][0:SA_C-1][D_W-1:0]  I_MAT_2,
  output logic                                 O_VLD,
  output logic [0:SA_R-1][0:SA_C-1][D_W-1:0]   O_RESULT,
  output logic                                 O_PE_SHIFT
);

  localparam int unsigned AccW     = acc_w(D_W, M_DIM);
  localparam int unsigned NumSteps = M_DIM + SA_R + SA_C - 2;
  localparam int unsigned CntW     = $clog2(NumSteps + 1);
  localparam int unsigned MIdxW    = (M_DIM > 1) ? $clog2(M_DIM) : 1;
  localparam logic [CntW-1:0] LastStep = CntW'(NumSteps - 1);

  localparam logic signed [AccW:0] SatMax = (AccW+1)'(2 ** (D_W - 1) - 1);
  localparam logic signed [AccW:0] SatMin = -SatMax - (AccW+1)'(1);
`ifdef SA_MM_RND_EN
  localparam logic signed [AccW:0] RndAdd = (AccW+1)'(2 ** (FRAC_W - 1));
`else
  localparam logic signed [AccW:0] RndAdd = '0;
`endif

  typedef logic [0:SA_R-1][0:SA_C-1][D_W-1:0] res_t;

  sa_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            vld_q, vld_d;
  logic            pe_shift_q, pe_shift_d;
  res_t            result_q, result_d;
  res_t            sat_all;
  logic            pe_clr, pe_en;

  logic [D_W-1:0]  a_w [SA_R][SA_C+1];
  logic [D_W-1:0]  b_w [SA_R+1][SA_C];
  logic [AccW-1:0] acc_arr [SA_R][SA_C];
  logic [SA_R-1:0] unused_a_edge;
  logic [SA_C-1:0] unused_b_edge;

  // Rescale an accumulator by FRAC_W bits and clamp to the D_W signed range.
  function automatic logic [D_W-1:0] sat_round(input logic [AccW-1:0] acc);
    logic signed [AccW:0] ext;
    logic signed [AccW:0] shf;
    ext = $signed({acc[AccW-1], acc}) + RndAdd;
    shf = ext >>> FRAC_W;
    if (shf > SatMax) begin
      return SatMax[D_W-1:0];
    end else if (shf < SatMin) begin
      return SatMin[D_W-1:0];
    end
    return shf[D_W-1:0];
  endfunction

  // Skewed west-edge feed: row i sees A[i][k-i] at step k, zero outside range.
  for (genvar gi = 0; gi < SA_R; gi++) begin : g_feed_a
    int a_idx;
    assign a_idx        = int'(cnt_q) - gi;
    assign a_w[gi][0]   = (a_idx >= 0 && a_idx < int'(M_DIM)) ?
                          I_MAT_1[gi][a_idx[MIdxW-1:0]] : '0;
    assign unused_a_edge[gi] = ^a_w[gi][SA_C];
  end

  // Skewed north-edge feed: column j sees B[k-j][j] at step k.
  for (genvar gj = 0; gj < SA_C; gj++) begin : g_feed_b
    int b_idx;
    assign b_idx        = int'(cnt_q) - gj;
    assign b_w[0][gj]   = (b_idx >= 0 && b_idx < int'(M_DIM)) ?
                          I_MAT_2[b_idx[MIdxW-1:0]][gj] : '0;
    assign unused_b_edge[gj] = ^b_w[SA_R][gj];
  end

  for (genvar gi = 0; gi < SA_R; gi++) begin : g_row
    for (genvar gj = 0; gj < SA_C; gj++) begin : g_col
      sa_pe #(
        .D_W   (D_W),
        .ACC_W (AccW)
      ) u_pe (
        .clk_i  (I_CLK),
        .rst_ni (I_ASYN_RSTN),
        .clr_i  (pe_clr),
        .en_i   (pe_en),
        .a_i    (a_w[gi][gj]),
        .b_i    (b_w[gi][gj]),
        .a_o    (a_w[gi][gj+1]),
        .b_o    (b_w[gi+1][gj]),
        .acc_o  (acc_arr[gi][gj])
      );
      assign sat_all[gi][gj] = sat_round(acc_arr[gi][gj]);
    end
  end

  // FSM state and step counter
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state; synchronous clear overrides everything, including start
  always_comb begin
    state_d = state_q;
    if (!I_SYNC_RSTN) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (I_START) state_d = StFeed;
        StFeed:  if (cnt_q == LastStep) state_d = StOut;
        StOut:   state_d = StDone;
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs: counter, PE controls and next values of the output registers
  always_comb begin
    cnt_d      = '0;
    pe_shift_d = (state_d == StFeed);
    vld_d      = vld_q;
    result_d   = result_q;
    pe_en      = (state_q == StFeed);
    // Accumulators are also zeroed on start so a run never inherits stale sums.
    pe_clr     = !I_SYNC_RSTN || (state_q == StIdle && I_START);
    if (!I_SYNC_RSTN) begin
      vld_d    = 1'b0;
      result_d = '0;
    end else begin
      if (state_q == StFeed && cnt_q != LastStep) begin
        cnt_d = cnt_q + CntW'(1);
      end
      if (state_q == StOut) begin
        vld_d    = 1'b1;
        result_d = sat_all;
      end
    end
  end

  // Registered outputs
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      vld_q      <= 1'b0;
      pe_shift_q <= 1'b0;
      result_q   <= '0;
    end else begin
      vld_q      <= vld_d;
      pe_shift_q <= pe_shift_d;
      result_q   <= result_d;
    end
  end

  assign O_VLD      = vld_q;
  assign O_PE_SHIFT = pe_shift_q;
  assign O_RESULT   = result_q;

endmodule

// File: tb/tb_sa_mm_engine.sv
// Directed self-checking bench for sa_mm_engine at default parameters.
module tb_sa_mm_engine;

  localparam int N = 16;
  typedef logic [0:N-1][0:N-1][7:0] mat_t;

  logic clk;
  logic arst_n;
  logic sync_n;
  logic start;
  mat_t m1, m2;
  logic vld;
  mat_t res;
  logic pe_shift;

  int n_cmp;
  int n_bad;

  sa_mm_engine u_dut (
    .I_CLK       (clk),
    .I_ASYN_RSTN (arst_n),
    .I_SYNC_RSTN (sync_n),
    .I_START     (start),
    .I_MAT_1     (m1),
    .I_MAT_2     (m2),
    .O_VLD       (vld),
    .O_RESULT    (res),
    .O_PE_SHIFT  (pe_shift)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_mat(input string tag, input mat_t exp);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        check_eq($sformatf("%s[%0d][%0d]", tag, i, j), 64'(res[i][j]), 64'(exp[i][j]));
      end
    end
  endtask

  // Pulse start and watch up to 60 edges; edge 0 is the start-sampling edge.
  task automatic run_mm(output int vld_edge, output int shift_cnt);
    @(negedge clk);
    start = 1'b1;
    vld_edge  = -1;
    shift_cnt = 0;
    for (int e = 0; e <= 60; e++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (pe_shift) shift_cnt++;
      if (vld && vld_edge < 0) vld_edge = e;
    end
  endtask

  task automatic sync_clear();
    @(negedge clk);
    sync_n = 1'b0;
    @(posedge clk);
    #1;
    sync_n = 1'b1;
  endtask

  function automatic mat_t fill(input logic [7:0] v);
    mat_t m;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) m[i][j] = v;
    return m;
  endfunction

  function automatic mat_t diag(input logic [7:0] v);
    mat_t m;
    m = '0;
    for (int i = 0; i < N; i++) m[i][i] = v;
    return m;
  endfunction

  function automatic mat_t ramp();
    mat_t m;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) m[i][j] = 8'((i * 16 + j) % 128);
    return m;
  endfunction

  initial begin
    int   ve, sc, seen;
    mat_t e033;
    clk    = 1'b0;
    arst_n = 1'b0;
    sync_n = 1'b1;
    start  = 1'b0;
    m1     = '0;
    m2     = '0;
    n_cmp  = 0;
    n_bad  = 0;

    #12;
    check_eq("rst_vld", 64'(vld), 64'd0);
    check_eq("rst_shift", 64'(pe_shift), 64'd0);
    check_eq("rst_result", 64'(|res), 64'd0);
    @(negedge clk);
    arst_n = 1'b1;

    // Identity times ramp: result equals B, with exact timing.
    m1 = diag(8'h20);
    m2 = ramp();
    run_mm(ve, sc);
    check_eq("id_vld_edge", 64'(ve), 64'd47);
    check_eq("id_shift_cycles", 64'(sc), 64'd46);
    check_mat("id_res", ramp());

    // Start in DONE is ignored.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("done_start_vld", 64'(vld), 64'd1);
    check_eq("done_start_shift", 64'(pe_shift), 64'd0);
    check_mat("done_start_res", ramp());

    sync_clear();
    check_eq("clr_vld", 64'(vld), 64'd0);
    check_eq("clr_result", 64'(|res), 64'd0);

    // 2.0 * 0.25 = 0.5 everywhere.
    m1 = fill(8'h40);
    m2 = diag(8'h08);
    run_mm(ve, sc);
    check_eq("half_vld_edge", 64'(ve), 64'd47);
    check_mat("half_res", fill(8'h10));
    sync_clear();

    // Positive saturation.
    m1 = fill(8'h7F);
    m2 = fill(8'h7F);
    run_mm(ve, sc);
    check_mat("satp_res", fill(8'h7F));
    sync_clear();

    // Negative saturation.
    m1 = fill(8'h80);
    run_mm(ve, sc);
    check_mat("satn_res", fill(8'h80));
    sync_clear();

    // 1/32 * 0.5 = 1/64: floor gives 0, round-half-up gives 1 LSB.
    m1 = '0;
    m2 = '0;
    m1[0][0] = 8'h01;
    m2[0][0] = 8'h10;
    e033 = '0;
`ifdef SA_MM_RND_EN
    e033[0][0] = 8'h01;
`endif
    run_mm(ve, sc);
    check_mat("rnd_res", e033);
    sync_clear();

    // Abort at FEED step 20, then restart on the very next cycle.
    m1 = diag(8'h20);
    m2 = ramp();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    sync_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("abort_shift", 64'(pe_shift), 64'd0);
    check_eq("abort_vld", 64'(vld), 64'd0);
    sync_n = 1'b1;
    run_mm(ve, sc);
    check_eq("restart_vld_edge", 64'(ve), 64'd47);
    check_eq("restart_shift_cycles", 64'(sc), 64'd46);
    check_mat("restart_res", ramp());

    // Asynchronous reset in DONE clears outputs without a clock edge.
    @(posedge clk);
    #3;
    arst_n = 1'b0;
    #1;
    check_eq("arst_done_vld", 64'(vld), 64'd0);
    check_eq("arst_done_shift", 64'(pe_shift), 64'd0);
    check_eq("arst_done_result", 64'(|res), 64'd0);
    @(negedge clk);
    arst_n = 1'b1;

    // Asynchronous reset mid-FEED discards the run.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    arst_n = 1'b0;
    #1;
    check_eq("arst_feed_shift", 64'(pe_shift), 64'd0);
    @(negedge clk);
    arst_n = 1'b1;
    seen = 0;
    for (int e = 0; e < 60; e++) begin
      @(posedge clk);
      #1;
      if (vld || pe_shift) seen++;
    end
    check_eq("arst_feed_no_vld", 64'(seen), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sa_mm_engine.md
SA_MM_ENGINE -- requirements
Module: sa_mm_engine

Interface
REQ-001 SHALL have parameter D_W, default 8: operand/result width, signed fixed point.
REQ-002 SHALL have parameter FRAC_W, default 5: fractional bits (0x20 = 1.0).
REQ-003 SHALL have parameters SA_R, SA_C, M_DIM, each default 16: result rows, result columns, inner dimension.
REQ-004 SHALL have port I_CLK, input, 1: single clock, all logic on the rising edge.
REQ-005 SHALL have port I_ASYN_RSTN, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port I_SYNC_RSTN, input, 1: synchronous active-low clear, driven by the controller's clear strobe.
REQ-007 SHALL have port I_START, input, 1: single-cycle start pulse.
REQ-008 SHALL have port I_MAT_1, input, [0:SA_R-1][0:M_DIM-1] x D_W: left operand A.
REQ-009 SHALL have port I_MAT_2, input, [0:M_DIM-1][0:SA_C-1] x D_W: right operand B.
REQ-010 SHALL have port O_VLD, output, 1: result valid, level.
REQ-011 SHALL have port O_RESULT, output, [0:SA_R-1][0:SA_C-1] x D_W: product A*B.
REQ-012 SHALL have port O_PE_SHIFT, output, 1: PE array shifting (compute in progress).

Function
REQ-013 SHALL implement an output-stationary systolic array of SA_R x SA_C PEs; operands skewed so PE(i,j) at step k accumulates A[i][k-i-j]*B[k-i-j][j] when 0 <= k-i-j < M_DIM.
REQ-014 SHALL implement FSM states IDLE, FEED, OUT, DONE: IDLE->FEED on I_START; FEED->OUT after K = M_DIM+SA_R+SA_C-2 steps; OUT->DONE after one cycle; DONE holds until clear.
REQ-015 SHALL sample I_START only in IDLE; I_START in FEED/OUT/DONE is ignored.
REQ-016 SHALL sample I_MAT_1/I_MAT_2 live each FEED cycle without latching them; the controller holds them stable from I_START until O_VLD.
REQ-017 SHALL compute each product as 2*D_W signed and accumulate in ACC_W = 2*D_W + clog2(M_DIM) bits (20 at defaults), with no overflow possible.
REQ-018 In OUT, SHALL shift each accumulator arithmetically right by FRAC_W and saturate to [-2^(D_W-1), 2^(D_W-1)-1]; rounding is per REQ-027.
REQ-019 SHALL register O_RESULT in OUT and assert O_VLD=1 from the same edge, i.e. first high after edge K+1 counted from the start-sampling edge (edge 47 at defaults).
REQ-020 SHALL hold O_VLD=1 and O_RESULT stable in DONE until I_SYNC_RSTN=0.
REQ-021 SHALL drive O_PE_SHIFT=1 exactly while in FEED, registered.
REQ-022 SHALL give I_SYNC_RSTN=0 priority over I_START; at the next edge: FSM->IDLE, step counter, accumulators, O_RESULT and O_VLD cleared to 0, O_PE_SHIFT=0, in any state including mid-FEED (abort).
REQ-023 SHALL accept a new I_START on the cycle after I_SYNC_RSTN returns to 1.

Reset
REQ-024 On I_ASYN_RSTN=0, SHALL immediately set FSM=IDLE, counter=0, all accumulators=0, O_VLD=0, O_PE_SHIFT=0 and O_RESULT=all zeros, independent of the clock.
REQ-025 Reset asserted mid-FEED SHALL discard the computation; no O_VLD is produced afterwards without a new I_START.

Configuration
REQ-026 SHALL support macro SA_MM_RND_EN.
REQ-027 With SA_MM_RND_EN defined, SHALL add 2^(FRAC_W-1) before the shift (round-half-up); without it, SHALL truncate (floor). Saturation and cycle timing SHALL be identical in both builds.

Structure
REQ-028 Package sa_pkg SHALL hold the default D_W/FRAC_W/array-size constants, the ACC_W function, and the FSM state enum.
REQ-029 The PE SHALL be sub-module sa_pe: registered A-right and B-down forwarding, MAC accumulator, synchronous clear.

Verification
REQ-030 A = diag 0x20, B[i][j] = (i*16+j) mod 128 -> O_RESULT == B; O_VLD rises on edge 47; O_PE_SHIFT high for exactly 46 cycles.
REQ-031 A = all 0x40 (2.0), B = diag 0x08 (0.25) -> every O_RESULT entry = 0x10 (0.5).
REQ-032 A = all 0x7F, B = all 0x7F -> all 0x7F; A = all 0x80, B = all 0x7F -> all 0x80.
REQ-033 A[0][0] = 0x01, B[0][0] = 0x10, all others 0 -> O_RESULT[0][0] = 0x01 with SA_MM_RND_EN, 0x00 without it; all other entries 0.
REQ-034 I_SYNC_RSTN=0 at FEED step 20 -> O_PE_SHIFT=0 next edge, O_VLD never rises; re-START with REQ-030 data -> correct result on edge 47.
REQ-035 I_START pulsed in DONE -> ignored, O_VLD/O_RESULT unchanged; I_ASYN_RSTN pulse in DONE -> all outputs 0 immediately.
